// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: ring / snooze / dismiss sequencer driving the alarm buzzer
module alarm_ring_ctrl #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3,
   parameter int BEEP_DIV   = 12500000
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       AL,
   input  logic       MATCH,
   input  logic       TICK_1HZ,
   input  logic       KEY0,
   input  logic       KEY1,
   output logic       BUZZ,
   output logic       RINGING,
   output logic       SNOOZED,
   output logic [2:0] SNOOZE_CNT
);
   localparam int MX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int SW = $clog2(MX + 1);
   localparam int BW = $clog2(BEEP_DIV + 1);
   localparam logic [SW-1:0] RING_LAST = SW'(RING_SEC - 1);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_DIV - 1);
   localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

   state_t        state;
   logic [1:0]    sync0, sync1;
   logic          key0_q, key1_q, match_s, match_q;
   logic [SW-1:0] sec_cnt;
   logic [BW-1:0] beep_cnt;
   logic          press0, press1, match_rise, can_snz, ring_to, snz_to;

   assign press0     = sync0[1] & ~key0_q;
   assign press1     = sync1[1] & ~key1_q;
   assign match_rise = match_s & ~match_q;
   assign can_snz    = SNOOZE_CNT < SNZ_MAX;
   assign ring_to    = TICK_1HZ && sec_cnt == RING_LAST;
   assign snz_to     = TICK_1HZ && sec_cnt == SNZ_LAST;
   assign RINGING    = state == RING;
   assign SNOOZED    = state == SNOOZE;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         sync0      <= '0;
         sync1      <= '0;
         key0_q     <= 1'b0;
         key1_q     <= 1'b0;
         match_s    <= 1'b0;
         match_q    <= 1'b0;
         sec_cnt    <= '0;
         beep_cnt   <= '0;
         BUZZ       <= 1'b0;
         SNOOZE_CNT <= '0;
      end else begin
         sync0   <= {sync0[0], KEY0};
         sync1   <= {sync1[0], KEY1};
         key0_q  <= sync0[1];
         key1_q  <= sync1[1];
         match_s <= MATCH;
         match_q <= match_s;
         if (AL) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            beep_cnt   <= '0;
            BUZZ       <= 1'b0;
            SNOOZE_CNT <= '0;
         end else begin
            case (state)
               IDLE: if (match_rise) begin
                  state      <= RING;
                  sec_cnt    <= '0;
                  beep_cnt   <= '0;
                  BUZZ       <= 1'b1;
                  SNOOZE_CNT <= '0;
               end
               RING: if (press0 || (ring_to && !can_snz)) begin
                  state   <= DONE;
                  sec_cnt <= '0;
                  BUZZ    <= 1'b0;
               end else if ((press1 || ring_to) && can_snz) begin
                  state      <= SNOOZE;
                  sec_cnt    <= '0;
                  BUZZ       <= 1'b0;
                  SNOOZE_CNT <= SNOOZE_CNT + 3'd1;
               end else begin
                  sec_cnt  <= sec_cnt + SW'(TICK_1HZ);
                  BUZZ     <= (beep_cnt == BEEP_LAST) ? ~BUZZ : BUZZ;
                  beep_cnt <= (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + BW'(1);
               end
               SNOOZE: if (press0) begin
                  state   <= DONE;
                  sec_cnt <= '0;
               end else if (snz_to) begin
                  state    <= RING;
                  sec_cnt  <= '0;
                  beep_cnt <= '0;
                  BUZZ     <= 1'b1;
               end else begin
                  sec_cnt <= sec_cnt + SW'(TICK_1HZ);
               end
               DONE: if (!match_s) begin
                  state   <= IDLE;
                  sec_cnt <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed and random stimulus against a countdown-based alarm model
module tb_alarm_ring_ctrl;
   localparam int RS = 4, SS = 3, MS = 2, BD = 2;

   logic       CLK = 0, RSTN = 0, AL = 0, MATCH = 0, TICK_1HZ = 0, KEY0 = 0, KEY1 = 0;
   logic       BUZZ, RINGING, SNOOZED;
   logic [2:0] SNOOZE_CNT;

   int checks = 0, errors = 0;
   int tdiv = 0, tc = 0, rises = 0;
   logic last_r = 0;

   // model: mode 0 idle, 1 ringing, 2 snoozing, 3 dismissed
   int m_mode = 0, m_left = 0, m_cyc = 0, m_cnt = 0;
   logic [2:0] k0h = 0, k1h = 0;
   logic [1:0] mh = 0;

   alarm_ring_ctrl #(.RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS), .BEEP_DIV(BD)) dut (
      .CLK(CLK), .RSTN(RSTN), .AL(AL), .MATCH(MATCH), .TICK_1HZ(TICK_1HZ),
      .KEY0(KEY0), .KEY1(KEY1), .BUZZ(BUZZ), .RINGING(RINGING),
      .SNOOZED(SNOOZED), .SNOOZE_CNT(SNOOZE_CNT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RSTN) begin
      logic p0, p1, rise, to;
      if (!RSTN) begin
         m_mode = 0; m_left = 0; m_cyc = 0; m_cnt = 0;
         k0h = 0; k1h = 0; mh = 0;
      end else begin
         p0   = k0h[1] & ~k0h[2];
         p1   = k1h[1] & ~k1h[2];
         rise = mh[0] & ~mh[1];
         to   = TICK_1HZ && m_left == 1;
         if (AL) begin
            m_mode = 0; m_cnt = 0;
         end else if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_left = RS; m_cyc = 0; m_cnt = 0; end
         end else if (m_mode == 1) begin
            if (p0) m_mode = 3;
            else if ((p1 || to) && m_cnt < MS) begin m_mode = 2; m_cnt++; m_left = SS; end
            else if (to) m_mode = 3;
            else begin
               if (TICK_1HZ) m_left--;
               m_cyc++;
            end
         end else if (m_mode == 2) begin
            if (p0) m_mode = 3;
            else if (to) begin m_mode = 1; m_left = RS; m_cyc = 0; end
            else if (TICK_1HZ) m_left--;
         end else if (!mh[0]) m_mode = 0;
         k0h = {k0h[1:0], KEY0};
         k1h = {k1h[1:0], KEY1};
         mh  = {mh[0], MATCH};
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      chk("ringing", RINGING, m_mode == 1);
      chk("snoozed", SNOOZED, m_mode == 2);
      chk("snooze_cnt", SNOOZE_CNT, m_cnt);
      chk("buzz", BUZZ, m_mode == 1 && (m_cyc / BD) % 2 == 0);
      if (RINGING === 1'b1 && !last_r) rises++;
      last_r = RINGING;
   end

   task automatic step(input bit t);
      @(negedge CLK);
      TICK_1HZ = t;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tc++;
         step(tdiv > 0 && tc % tdiv == 0);
      end
   endtask

   task automatic wait_ring(input logic v, input int lim, input string nm);
      for (int i = 0; i < lim && RINGING !== v; i++) run(1);
      chk(nm, RINGING, v);
   endtask

   task automatic press(input bit k0, input bit k1);
      KEY0 = k0; KEY1 = k1;
      run(3);
      KEY0 = 0; KEY1 = 0;
      run(3);
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_ring"}, RINGING, 0);
      chk({nm, "_snz"}, SNOOZED, 0);
      chk({nm, "_buzz"}, BUZZ, 0);
      chk({nm, "_cnt"}, SNOOZE_CNT, 0);
   endtask

   initial begin
      run(2);
      all_zero("reset");
      RSTN = 1;
      run(2);
      // basic ring, beep pattern, dismiss, no re-trigger in same minute
      MATCH = 1;
      run(1); chk("t1_pre", RINGING, 0);
      run(1); chk("t1_ring", RINGING, 1); chk("t1_b0", BUZZ, 1);
      run(1); chk("t1_b1", BUZZ, 1);
      run(1); chk("t1_b2", BUZZ, 0);
      run(1); chk("t1_b3", BUZZ, 0);
      run(1); chk("t1_b4", BUZZ, 1);
      press(1, 0);
      chk("t1_done", RINGING, 0); chk("t1_dbuzz", BUZZ, 0);
      run(10); chk("t1_noretrig", RINGING, 0);
      MATCH = 0; run(3);
      // unattended: three bursts, two auto snoozes
      tdiv = 3; tc = 0; rises = 0;
      MATCH = 1; run(80);
      chk("t2_bursts", rises, 3); chk("t2_cnt", SNOOZE_CNT, 2);
      chk("t2_ring", RINGING, 0); chk("t2_snz", SNOOZED, 0);
      MATCH = 0; run(3);
      // manual snoozes up to the limit
      tdiv = 5;
      MATCH = 1; wait_ring(1, 10, "t3_wa");
      press(0, 1); chk("t3_s1", SNOOZED, 1); chk("t3_c1", SNOOZE_CNT, 1);
      wait_ring(1, 30, "t3_wb");
      press(0, 1); chk("t3_s2", SNOOZED, 1); chk("t3_c2", SNOOZE_CNT, 2);
      wait_ring(1, 30, "t3_wc");
      press(0, 1); chk("t3_ign", RINGING, 1); chk("t3_ignsnz", SNOOZED, 0);
      wait_ring(0, 40, "t3_wd");
      chk("t3_done", SNOOZED, 0); chk("t3_c3", SNOOZE_CNT, 2);
      MATCH = 0; run(3);
      // both keys together, then key1 on the terminal tick
      tdiv = 0;
      MATCH = 1; run(2); chk("t4_ring", RINGING, 1);
      press(1, 1);
      chk("t4_done", RINGING, 0); chk("t4_dsnz", SNOOZED, 0); chk("t4_cnt", SNOOZE_CNT, 0);
      MATCH = 0; run(3);
      MATCH = 1; run(2);
      for (int i = 0; i < 3; i++) begin step(1); step(0); end
      KEY1 = 1;
      step(0); step(1); step(0);
      chk("t4_keytick", SNOOZED, 1); chk("t4_once", SNOOZE_CNT, 1);
      KEY1 = 0; run(3);
      press(1, 0); MATCH = 0; run(3);
      // AL override mid-ring, and blocked trigger
      MATCH = 1; run(2); press(0, 1);
      for (int i = 0; i < 3; i++) begin step(1); step(0); end
      run(1); chk("t5_ring", RINGING, 1); chk("t5_cnt", SNOOZE_CNT, 1);
      AL = 1; run(1); all_zero("t5_al");
      MATCH = 0; run(2); MATCH = 1; run(4); chk("t5_blk", RINGING, 0);
      AL = 0; run(4); chk("t5_after", RINGING, 0);
      MATCH = 0; run(3);
      // asynchronous reset during snooze
      MATCH = 1; run(2); press(0, 1); chk("t6_snz", SNOOZED, 1);
      @(posedge CLK); #2 RSTN = 0; #1 all_zero("t6_async");
      MATCH = 0; run(2); RSTN = 1; run(2);
      MATCH = 1; run(2); chk("t6_ring", RINGING, 1); chk("t6_cnt", SNOOZE_CNT, 0);
      press(1, 0); MATCH = 0; run(3);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) MATCH = ~MATCH;
         AL = AL ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 149) == 0);
         KEY0 = ($urandom_range(0, 29) == 0) || (KEY0 && $urandom_range(0, 2) != 0);
         KEY1 = ($urandom_range(0, 11) == 0) || (KEY1 && $urandom_range(0, 2) != 0);
      end
      run(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Sequences the alarm sounder once the alarm-compare logic flags a time match. It takes the compare block's match level, the 1 Hz tick and the KEY0/KEY1 pushbuttons, and runs a ring / snooze / dismiss state machine. It drives the buzzer and status outputs at the top level of the DE2 clock. Entering alarm-set mode (AL) forces it idle.

## Interface
- RING_SEC, default 60: ticks a ring burst lasts before auto-snooze or give-up.
- SNOOZE_SEC, default 300: ticks spent in snooze before re-ringing.
- MAX_SNOOZE, default 3: maximum snoozes (manual and auto combined) per alarm event; range 0..7.
- BEEP_DIV, default 12500000: CLK cycles per BUZZ half-period while ringing.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- AL  input  1  alarm-set mode; high forces IDLE and blocks triggering.
- MATCH  input  1  alarm-compare match level, synchronous to CLK; high for the whole matched minute.
- TICK_1HZ  input  1  one-CLK-cycle pulse per second.
- KEY0  input  1  raw dismiss button, high = pressed, asynchronous.
- KEY1  input  1  raw snooze button, high = pressed, asynchronous.
- BUZZ  output  1  buzzer drive, square wave in RING, 0 otherwise.
- RINGING  output  1  high while in RING.
- SNOOZED  output  1  high while in SNOOZE.
- SNOOZE_CNT  output  3  snoozes used in the current alarm event.

## Operation
- KEY0 and KEY1 each pass through a 2-flop synchronizer (SYNC0, SYNC1).
- A press is the rising edge of SYNC1 against its one-cycle-delayed copy. Each press gives one pulse; holding a key gives no repeats.
- MATCH rise = MATCH high while its registered copy is low.
- States:
  - IDLE: MATCH rise with AL low -> RING. Entry clears sec_cnt and SNOOZE_CNT.
  - RING: KEY0 press -> DONE.
  - RING: KEY1 press with SNOOZE_CNT < MAX_SNOOZE -> SNOOZE and SNOOZE_CNT+1. KEY1 press at the limit is ignored.
  - RING timeout (RING_SEC-th tick since entry): -> SNOOZE with SNOOZE_CNT+1 if SNOOZE_CNT < MAX_SNOOZE, else -> DONE.
  - SNOOZE: KEY0 press -> DONE. SNOOZE_SEC-th tick since entry -> RING. KEY1 is ignored.
  - DONE: MATCH low -> IDLE. This stops a re-trigger within the same matched minute.
- sec_cnt clears on every state entry and increments on TICK_1HZ. Its width is $clog2(max(RING_SEC,SNOOZE_SEC)+1). It never wraps, because it leaves the state at its terminal value.
- Priority, same cycle:
  - AL high beats everything else.
  - KEY0 beats KEY1.
  - Any key press beats a timeout tick.
- AL high in any state -> IDLE at the next edge, with sec_cnt, SNOOZE_CNT, BUZZ and the beep counter cleared.
- MATCH falling during RING or SNOOZE has no effect; the sequence runs to completion.
- MAX_SNOOZE = 0: KEY1 is always ignored and a RING timeout goes to DONE.
- BUZZ:
  - Set to 1 on the RING entry edge; the beep counter clears to 0 at the same time.
  - Toggles every BEEP_DIV cycles.
  - Forced to 0 on the edge that leaves RING.
- RINGING and SNOOZED are decoded from the state register.
- SNOOZE_CNT holds its value through DONE and IDLE until the next RING entry from IDLE.

## Timing
- Reset (RSTN low, asynchronous): state IDLE; BUZZ, RINGING, SNOOZED = 0; SNOOZE_CNT = 0; synchronizers, edge registers and counters = 0.
- MATCH rise: MATCH first sampled high at edge m -> RING (RINGING = 1, BUZZ = 1) after edge m+1.
- Key latency: raw key first sampled high at edge n -> state changes at edge n+2.
- Tick-to-transition: the state change occurs at the edge that samples the terminal TICK_1HZ.
- DONE -> IDLE: one edge after MATCH is sampled low.

## Test plan
Test parameters: RING_SEC = 4, SNOOZE_SEC = 3, MAX_SNOOZE = 2, BEEP_DIV = 2.
- MATCH 0->1 with AL low -> RINGING = 1 one edge later. BUZZ reads 1,1,0,0,1,... KEY0 press -> DONE, BUZZ = 0. MATCH held high -> no re-ring. MATCH low -> IDLE.
- Ring with no keys -> RING 4 ticks, SNOOZE 3 ticks (SNOOZE_CNT = 1), RING 4, SNOOZE (SNOOZE_CNT = 2), RING 4 -> DONE.
- KEY1 pressed twice in separate RING bursts -> SNOOZE_CNT = 2. Third KEY1 press in RING is ignored; RINGING stays 1 until timeout -> DONE.
- KEY0 and KEY1 pressed in the same cycle during RING -> DONE, SNOOZE_CNT unchanged. KEY1 press coinciding with the 4th tick -> SNOOZE via the key path, SNOOZE_CNT +1 once only.
- AL raised mid-RING -> IDLE next edge, all outputs 0. MATCH rise while AL is high -> stays IDLE.
- RSTN asserted mid-SNOOZE -> all outputs 0 immediately, without waiting for a clock edge. After release, a MATCH rise -> RING with SNOOZE_CNT = 0.
